io_step_sequencer: RTL and testbench

Programmable output-pattern sequencer that drives a bank of user-project IO pins through a table of up to DEPTH steps, each held for a programmed number of clocks, with optional looping and an optional external-pin trigger. It sits in the user project area between the management-side configuration logic and the mprj_io output/enable pins. It replaces ad-hoc firmware bit-banging of patterns such as 0x01..0x0A, 0xFF, 0x00 on mprj_io[7:0] with cycle-exact hardware timing.

---
 rtl/io_step_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_io_step_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_step_sequencer.sv
// Table-driven output-pattern sequencer for user IO pins: each step drives a
// pattern for hold+1 cycles, with pass looping and an optional synchronised pin trigger.
module io_step_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_hold,
  input  logic [AW-1:0]    cfg_last,
  input  logic [7:0]       cfg_loops,
  input  logic             cfg_trig_en,
  input  logic             start,
  input  logic             abort,
  input  logic             trig_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q  [DEPTH];
  logic [CNT_W-1:0] hold_q [DEPTH];
  logic [AW-1:0]    step_q, step_d, last_q, last_d, step_inc_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loops_q, loops_d, rem_q, rem_d;
  logic             trig_s1_q, trig_s2_q, trig_s3_q, trig_edge_q;
  logic [WIDTH-1:0] io_out_q, io_out_d, io_oeb_q, io_oeb_d;
  logic             busy_q, busy_d, done_q, done_d;

  assign step_inc_s = step_q + AW'(1);

  // Step table; only writable while the sequencer is idle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else if (cfg_we && (state_q == S_IDLE)) begin
      pat_q[cfg_addr]  <= cfg_pattern;
      hold_q[cfg_addr] <= cfg_hold;
    end
  end

  // Two-flop synchroniser on the pin, then a registered rising-edge flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_s3_q   <= 1'b0;
      trig_edge_q <= 1'b0;
    end else begin
      trig_s1_q   <= trig_in;
      trig_s2_q   <= trig_s1_q;
      trig_s3_q   <= trig_s2_q;
      trig_edge_q <= trig_s2_q & ~trig_s3_q;
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      loops_q  <= 8'd0;
      rem_q    <= 8'd0;
      io_out_q <= '0;
      io_oeb_q <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      loops_q  <= loops_d;
      rem_q    <= rem_d;
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they land with it.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    loops_d = loops_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      step_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          step_d = '0;
          if (start) begin
            last_d  = cfg_last;
            loops_d = cfg_loops;
            rem_d   = cfg_loops;
            if (cfg_trig_en) begin
              state_d = S_ARM;
            end else begin
              state_d = S_RUN;
              cnt_d   = hold_q[0];
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ARM: begin
          if (trig_edge_q) begin
            state_d = S_RUN;
            step_d  = '0;
            cnt_d   = hold_q[0];
          end else begin
            state_d = S_ARM;
          end
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (step_q < last_q) begin
            step_d = step_inc_s;
            cnt_d  = hold_q[step_inc_s];
          end else if ((loops_q == 8'd0) || (rem_q > 8'd1)) begin
            // Wrap to the next pass; an infinite run never counts down.
            step_d = '0;
            cnt_d  = hold_q[0];
            if (loops_q != 8'd0) begin
              rem_d = rem_q - 8'd1;
            end else begin
              rem_d = rem_q;
            end
          end else begin
            state_d = S_IDLE;
            step_d  = '0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          step_d  = '0;
        end
      endcase
    end

    if (state_d == S_RUN) begin
      io_out_d = pat_q[step_d];
      io_oeb_d = {WIDTH{1'b0}};
    end else begin
      io_out_d = {WIDTH{1'b0}};
      io_oeb_d = {WIDTH{1'b1}};
    end
    busy_d = (state_d != S_IDLE);
  end

  assign io_out   = io_out_q;
  assign io_oeb   = io_oeb_q;
  assign busy     = busy_q;
  assign step_idx = step_q;
  assign done     = done_q;

endmodule

// File: tb/tb_io_step_sequencer.sv
// Directed self-checking bench for io_step_sequencer; each task drives one
// scenario and compares {io_out, io_oeb, busy, done, step_idx} against hand values.
module tb_io_step_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int AW    = 4;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i, cfg_we, cfg_trig_en, start, abort, trig_in;
  logic [AW-1:0]    cfg_addr, cfg_last, step_idx;
  logic [WIDTH-1:0] cfg_pattern, io_out, io_oeb;
  logic [CNT_W-1:0] cfg_hold;
  logic [7:0]       cfg_loops;
  logic             busy, done;
  logic [21:0]      obs, exp_v;

  int checks   = 0;
  int failures = 0;

  io_step_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_pattern(cfg_pattern), .cfg_hold(cfg_hold), .cfg_last(cfg_last),
    .cfg_loops(cfg_loops), .cfg_trig_en(cfg_trig_en), .start(start), .abort(abort),
    .trig_in(trig_in), .io_out(io_out), .io_oeb(io_oeb), .busy(busy),
    .step_idx(step_idx), .done(done)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  assign obs = {io_out, io_oeb, busy, done, step_idx};

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [7:0] cnt_val(input int i);
    if (i < 10) return 8'(i + 1);
    else if (i == 10) return 8'hFF;
    else return 8'h00;
  endfunction

  task automatic write_entry(input int a, input logic [7:0] p, input logic [15:0] h);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_pattern = p; cfg_hold = h;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int last, input logic [7:0] loops, input logic trig);
    cfg_last = 4'(last); cfg_loops = loops; cfg_trig_en = trig; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    tick(); tick();
    exp_v = {8'h00, 8'hFF, 1'b0, 1'b0, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_values: got %h expected %h", obs, exp_v);
    end
    wb_rst_i = 1'b0;
    tick();
  endtask

  task automatic test_counting();
    for (int i = 0; i < 12; i++) write_entry(i, cnt_val(i), 16'd9);
    do_start(11, 8'd1, 1'b0);
    for (int c = 0; c < 120; c++) begin
      exp_v = {cnt_val(c / 10), 8'h00, 1'b1, 1'b0, 4'(c / 10)};
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL counting cycle %0d: got %h expected %h", c, obs, exp_v);
      end
      tick();
    end
    exp_v = {8'h00, 8'hFF, 1'b0, 1'b1, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL counting_done: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = {8'h00, 8'hFF, 1'b0, 1'b0, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL counting_done_clear: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_looping();
    write_entry(0, 8'h55, 16'd0);
    write_entry(1, 8'hAA, 16'd2);
    do_start(1, 8'd3, 1'b0);
    for (int c = 0; c < 12; c++) begin
      exp_v = ((c % 4) == 0) ? {8'h55, 8'h00, 1'b1, 1'b0, 4'd0}
                             : {8'hAA, 8'h00, 1'b1, 1'b0, 4'd1};
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL looping cycle %0d: got %h expected %h", c, obs, exp_v);
      end
      tick();
    end
    exp_v = {8'h00, 8'hFF, 1'b0, 1'b1, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL looping_done: got %h expected %h", obs, exp_v);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL looping_single_done: got %b expected 0", done);
    end
  endtask

  task automatic test_trigger();
    trig_in = 1'b0;
    do_start(0, 8'd1, 1'b1);
    exp_v = {8'h00, 8'hFF, 1'b1, 1'b0, 4'd0};
    for (int c = 0; c < 50; c++) begin
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL trig_armed cycle %0d: got %h expected %h", c, obs, exp_v);
      end
      tick();
    end
    trig_in = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL trig_early: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = {8'h55, 8'h00, 1'b1, 1'b0, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL trig_run: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = {8'h00, 8'hFF, 1'b0, 1'b1, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL trig_done: got %h expected %h", obs, exp_v);
    end
    trig_in = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    do_start(1, 8'd0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      exp_v = ((c % 4) == 0) ? {8'h55, 8'h00, 1'b1, 1'b0, 4'd0}
                             : {8'hAA, 8'h00, 1'b1, 1'b0, 4'd1};
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL infinite cycle %0d: got %h expected %h", c, obs, exp_v);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_v = {8'h00, 8'hFF, 1'b0, 1'b0, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL abort_idle: got %h expected %h", obs, exp_v);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL abort_stay cycle %0d: got %h expected %h", c, obs, exp_v);
      end
    end
    abort = 1'b1;
    do_start(1, 8'd1, 1'b0);
    abort = 1'b0;
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL start_abort_same: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_locking();
    int waited;
    do_start(1, 8'd1, 1'b0);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_pattern = 8'h3C; cfg_hold = 16'd0;
    cfg_last = 4'd0; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    exp_v = {8'hAA, 8'h00, 1'b1, 1'b0, 4'd1};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL lock_start_ignored: got %h expected %h", obs, exp_v);
    end
    waited = 0;
    while (done !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL lock_wait_done: got done=%b expected 1 within 10 cycles", done);
    end
    tick();
    do_start(1, 8'd1, 1'b0);
    exp_v = {8'h55, 8'h00, 1'b1, 1'b0, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL lock_entry0_kept: got %h expected %h", obs, exp_v);
    end
    tick(); tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_run();
    do_start(11, 8'd1, 1'b0);
    for (int c = 0; c < 36; c++) tick();
    exp_v = {cnt_val(5), 8'h00, 1'b1, 1'b0, 4'd5};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL midrun_step5: got %h expected %h", obs, exp_v);
    end
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    exp_v = {8'h00, 8'hFF, 1'b0, 1'b0, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL midrun_reset: got %h expected %h", obs, exp_v);
    end
    tick();
    do_start(11, 8'd1, 1'b0);
    for (int c = 0; c < 12; c++) begin
      exp_v = {8'h00, 8'h00, 1'b1, 1'b0, 4'(c)};
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL cleared_table cycle %0d: got %h expected %h", c, obs, exp_v);
      end
      tick();
    end
    exp_v = {8'h00, 8'hFF, 1'b0, 1'b1, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL cleared_done: got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    wb_rst_i = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_pattern = '0; cfg_hold = '0;
    cfg_last = '0; cfg_loops = 8'd0; cfg_trig_en = 1'b0; start = 1'b0;
    abort = 1'b0; trig_in = 1'b0;
    test_reset();
    test_counting();
    test_looping();
    test_trigger();
    test_abort();
    test_locking();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
